// File: rtl/pc_gen.sv
// Program-counter generator: five-source next-PC selection, fetch handshake,
// BOOT/RUN/HALT control, misaligned-redirect detection and a circular return-address stack.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_pc_en,
  input  logic            i_pc_ready,
  output logic            o_pc_valid,
  output logic [XLEN-1:0] o_curr_pc,
  input  logic            i_redirect_req,
  input  logic [XLEN-1:0] i_redirect_target,
  input  logic            i_trap_req,
  input  logic [XLEN-1:0] i_trap_vec,
  input  logic            i_call_push,
  input  logic            i_ret_pop,
  input  logic            i_halt_req,
  input  logic            i_resume_req,
  output logic            o_misalign_fault,
  output logic            o_ras_empty,
  output logic            o_halted
);

  localparam int              PTR_W      = $clog2(RAS_DEPTH);
  localparam int              CNT_W      = PTR_W + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  function automatic logic is_aligned(input logic [XLEN-1:0] a);
    return (a & ALIGN_MASK) == '0;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [XLEN-1:0]  r_pc, w_pc_nxt;
  logic             r_fault, w_fault_nxt;
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_ras [RAS_DEPTH];

  logic             w_adv, w_accept, w_clear, w_pop, w_push;
  logic             w_ras_nonempty;
  logic [XLEN-1:0]  w_seq_pc;

  assign w_adv          = (r_state == S_RUN) && i_pc_en && i_pc_ready;
  assign w_ras_nonempty = (r_count != '0);
  assign w_seq_pc       = r_pc + STEP;
  // w_accept is only raised for an aligned redirect or a plain advance, never under trap
  assign w_pop          = w_accept && i_ret_pop && w_ras_nonempty;
  assign w_push         = w_accept && i_call_push;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_fault_nxt = 1'b0;
    w_accept    = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (i_trap_req) begin
          w_pc_nxt = i_trap_vec & ~ALIGN_MASK;
          w_clear  = 1'b1;
        end else if (i_redirect_req) begin
          if (is_aligned(i_redirect_target)) begin
            w_pc_nxt = i_redirect_target;
            w_accept = 1'b1;
          end else begin
            w_fault_nxt = 1'b1;
          end
        end else if (w_adv) begin
          w_accept = 1'b1;
          w_pc_nxt = (i_ret_pop && w_ras_nonempty) ? r_ras[r_top] : w_seq_pc;
        end
        if (i_halt_req && !i_trap_req && !i_redirect_req)
          w_state_nxt = S_HALT;
      end
      S_HALT: begin
        if (i_trap_req) begin
          w_pc_nxt    = i_trap_vec & ~ALIGN_MASK;
          w_clear     = 1'b1;
          w_state_nxt = S_RUN;
        end else if (i_resume_req) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_VECTOR;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  // Pop-then-push rewrites the top slot in place; a push when full lands on the oldest slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (w_clear) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (w_pop && !w_push) begin
      r_top   <= r_top - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end else if (w_push && !w_pop) begin
      r_top <= r_top + PTR_W'(1);
      if (r_count != FULL)
        r_count <= r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      if (w_pop)
        r_ras[r_top] <= w_seq_pc;
      else
        r_ras[r_top + PTR_W'(1)] <= w_seq_pc;
    end
  end

  assign o_curr_pc        = r_pc;
  assign o_pc_valid       = (r_state == S_RUN);
  assign o_halted         = (r_state == S_HALT);
  assign o_misalign_fault = r_fault;
  assign o_ras_empty      = (r_count == '0);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: inputs driven and outputs checked on the falling clock edge.
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_en, pc_ready, redirect_req, trap_req, call_push, ret_pop, halt_req, resume_req;
  logic [31:0] redirect_target, trap_vec;
  logic        pc_valid, misalign_fault, ras_empty, halted;
  logic [31:0] curr_pc;
  int          checks = 0;
  int          errors = 0;

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pc_en(pc_en), .i_pc_ready(pc_ready), .o_pc_valid(pc_valid), .o_curr_pc(curr_pc),
    .i_redirect_req(redirect_req), .i_redirect_target(redirect_target),
    .i_trap_req(trap_req), .i_trap_vec(trap_vec),
    .i_call_push(call_push), .i_ret_pop(ret_pop),
    .i_halt_req(halt_req), .i_resume_req(resume_req),
    .o_misalign_fault(misalign_fault), .o_ras_empty(ras_empty), .o_halted(halted)
  );

  always #5 clk = ~clk;

  task automatic idle();
    pc_en = 1; pc_ready = 1; redirect_req = 0; trap_req = 0; call_push = 0;
    ret_pop = 0; halt_req = 0; resume_req = 0; redirect_target = '0; trap_vec = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic jump(input logic [31:0] t);
    redirect_req = 1; redirect_target = t;
    step();
    redirect_req = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle();
    #12;
    checks++; if (curr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 00000000", curr_pc); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", pc_valid); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL rst_ras_empty: got %b want 1", ras_empty); end
    checks++; if (halted !== 1'b0 || misalign_fault !== 1'b0) begin errors++; $display("FAIL rst_flags: halted %b fault %b want 0 0", halted, misalign_fault); end
    @(negedge clk); rst_n = 1;
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b want 0", pc_valid); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      step();
      exp = 32'(i * 4);
      checks++; if (pc_valid !== 1'b1 || curr_pc !== exp) begin errors++; $display("FAIL seq_%0d: got valid %b pc %h want 1 %h", i, pc_valid, curr_pc, exp); end
    end
  endtask

  task automatic test_stall_redirect();
    step();
    checks++; if (curr_pc !== 32'h10) begin errors++; $display("FAIL pc_0x10: got %h want 00000010", curr_pc); end
    pc_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (curr_pc !== 32'h10) begin errors++; $display("FAIL stall_%0d: got %h want 00000010", i, curr_pc); end
    end
    jump(32'h200);
    checks++; if (curr_pc !== 32'h200) begin errors++; $display("FAIL stall_redirect: got %h want 00000200", curr_pc); end
    pc_ready = 1;
  endtask

  task automatic test_misalign_trap();
    jump(32'h102);
    checks++; if (curr_pc !== 32'h200 || misalign_fault !== 1'b1) begin errors++; $display("FAIL misalign: got pc %h fault %b want 00000200 1", curr_pc, misalign_fault); end
    step();
    checks++; if (curr_pc !== 32'h204 || misalign_fault !== 1'b0) begin errors++; $display("FAIL misalign_pulse: got pc %h fault %b want 00000204 0", curr_pc, misalign_fault); end
    call_push = 1; step(); call_push = 0;
    checks++; if (curr_pc !== 32'h208 || ras_empty !== 1'b0) begin errors++; $display("FAIL push_pre_trap: got pc %h empty %b want 00000208 0", curr_pc, ras_empty); end
    trap_req = 1; trap_vec = 32'h80; redirect_req = 1; redirect_target = 32'h300;
    step(); idle();
    checks++; if (curr_pc !== 32'h80 || ras_empty !== 1'b1) begin errors++; $display("FAIL trap_prio: got pc %h empty %b want 00000080 1", curr_pc, ras_empty); end
  endtask

  task automatic test_ras_call_ret();
    jump(32'h40);
    call_push = 1; jump(32'h400); call_push = 0;
    checks++; if (curr_pc !== 32'h400 || ras_empty !== 1'b0) begin errors++; $display("FAIL call: got pc %h empty %b want 00000400 0", curr_pc, ras_empty); end
    step();
    ret_pop = 1; step(); ret_pop = 0;
    checks++; if (curr_pc !== 32'h44 || ras_empty !== 1'b1) begin errors++; $display("FAIL ret: got pc %h empty %b want 00000044 1", curr_pc, ras_empty); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp [5] = '{32'h1014, 32'h1010, 32'h100C, 32'h1008, 32'h100C};
    jump(32'h1000);
    call_push = 1;
    for (int i = 0; i < 5; i++) step();
    call_push = 0;
    checks++; if (curr_pc !== 32'h1014) begin errors++; $display("FAIL push5_pc: got %h want 00001014", curr_pc); end
    ret_pop = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (curr_pc !== exp[i]) begin errors++; $display("FAIL pop_%0d: got %h want %h", i, curr_pc, exp[i]); end
    end
    ret_pop = 0;
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL pop_empty: got %b want 1", ras_empty); end
  endtask

  task automatic test_wrap();
    jump(32'hFFFF_FFF8);
    step();
    checks++; if (curr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL pre_wrap: got %h want fffffffc", curr_pc); end
    step();
    checks++; if (curr_pc !== 32'h0) begin errors++; $display("FAIL wrap: got %h want 00000000", curr_pc); end
  endtask

  task automatic test_halt();
    pc_en = 0; halt_req = 1; step(); halt_req = 0; pc_en = 1;
    checks++; if (halted !== 1'b1 || pc_valid !== 1'b0 || curr_pc !== 32'h0) begin errors++; $display("FAIL halt: got halted %b valid %b pc %h want 1 0 00000000", halted, pc_valid, curr_pc); end
    redirect_req = 1; redirect_target = 32'h500;
    step(); step(); redirect_req = 0;
    checks++; if (halted !== 1'b1 || curr_pc !== 32'h0) begin errors++; $display("FAIL halt_frozen: got halted %b pc %h want 1 00000000", halted, curr_pc); end
    resume_req = 1; step(); resume_req = 0;
    checks++; if (halted !== 1'b0 || pc_valid !== 1'b1 || curr_pc !== 32'h0) begin errors++; $display("FAIL resume: got halted %b valid %b pc %h want 0 1 00000000", halted, pc_valid, curr_pc); end
    step();
    checks++; if (curr_pc !== 32'h4) begin errors++; $display("FAIL resume_step: got %h want 00000004", curr_pc); end
  endtask

  task automatic test_trap_in_halt();
    pc_en = 0; halt_req = 1; step(); idle();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt2: got %b want 1", halted); end
    trap_req = 1; trap_vec = 32'h123; step(); idle();
    checks++; if (halted !== 1'b0 || pc_valid !== 1'b1 || curr_pc !== 32'h120) begin errors++; $display("FAIL trap_halt: got halted %b valid %b pc %h want 0 1 00000120", halted, pc_valid, curr_pc); end
  endtask

  task automatic test_async_reset();
    call_push = 1; step(); call_push = 0;
    checks++; if (curr_pc !== 32'h124 || ras_empty !== 1'b0) begin errors++; $display("FAIL pre_reset: got pc %h empty %b want 00000124 0", curr_pc, ras_empty); end
    #2 rst_n = 0;
    #1;
    checks++; if (curr_pc !== 32'h0 || pc_valid !== 1'b0 || ras_empty !== 1'b1) begin errors++; $display("FAIL async_reset: got pc %h valid %b empty %b want 00000000 0 1", curr_pc, pc_valid, ras_empty); end
    @(negedge clk); rst_n = 1;
    step();
    checks++; if (pc_valid !== 1'b1 || curr_pc !== 32'h0) begin errors++; $display("FAIL reboot: got valid %b pc %h want 1 00000000", pc_valid, curr_pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_misalign_trap();
    test_ras_call_ret();
    test_ras_overflow();
    test_wrap();
    test_halt();
    test_trap_in_halt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator, the successor to the single-register PC of the single-cycle core. It holds the current fetch address and selects the next one from five sources, in priority order: trap vector, redirect target, stall hold, return-address-stack prediction, sequential increment. It adds a fetch valid/ready handshake, a halt/resume state machine, misaligned-target detection and a small return-address stack (RAS). It sits between the branch/jump/trap logic and the instruction-memory fetch port.

Parameters:
XLEN, 32, address width in bits
RESET_VECTOR, 32'h0000_0000, curr_pc value after reset
IALIGN, 4, instruction alignment and sequential increment in bytes; legal values 2 or 4
RAS_DEPTH, 4, return-address-stack entries; power of two, at least 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pc_en  in  1  core-side enable; 0 means stall
pc_ready  in  1  fetch port accepts curr_pc this cycle
pc_valid  out  1  curr_pc is a valid fetch address
curr_pc  out  XLEN  current PC
redirect_req  in  1  branch/jump taken
redirect_target  in  XLEN  branch/jump destination
trap_req  in  1  trap or exception entry
trap_vec  in  XLEN  trap handler address
call_push  in  1  current instruction is a call; push curr_pc+IALIGN
ret_pop  in  1  current instruction is a return; predict from RAS
halt_req  in  1  enter HALT
resume_req  in  1  leave HALT
misalign_fault  out  1  one-cycle pulse: redirect target rejected
ras_empty  out  1  RAS holds no entries
halted  out  1  state is HALT

Behaviour:
- Reset (asynchronous, active-low):
  - curr_pc = RESET_VECTOR, state = BOOT, pc_valid = 0.
  - misalign_fault = 0, halted = 0, RAS count = 0, ras_empty = 1.
- FSM states:
  - BOOT always moves to RUN on the next clock. pc_valid stays 0 during BOOT, so the first valid fetch is the cycle after reset release.
  - RUN: pc_valid = 1. halt_req moves to HALT, unless trap_req or redirect_req is asserted in the same cycle; those apply and halt_req is ignored that cycle.
  - HALT: pc_valid = 0, halted = 1, curr_pc held. resume_req or trap_req moves to RUN. When trap_req causes the exit, curr_pc is loaded with the trap vector.
- "adv" is the accepted-advance condition: state == RUN && pc_en && pc_ready.
- Next-PC selection in RUN, highest priority first:
  1. trap_req: curr_pc <= trap_vec with the low log2(IALIGN) bits forced to 0. Applies regardless of pc_en/pc_ready. Clears the RAS (count = 0).
  2. redirect_req: if the target's low log2(IALIGN) bits are 0, curr_pc <= redirect_target regardless of stall. Otherwise curr_pc is held and misalign_fault = 1 for exactly the next cycle.
  3. !adv: hold curr_pc.
  4. ret_pop && !ras_empty: curr_pc <= RAS top, then pop.
  5. Otherwise: curr_pc <= curr_pc + IALIGN, modulo 2^XLEN. 0xFFFF_FFFC + 4 wraps to 0.
- RAS rules:
  - A push happens on call_push when adv or an accepted redirect occurs. The pushed value is curr_pc + IALIGN, modulo 2^XLEN.
  - A push when full overwrites the oldest entry as a circular buffer; count saturates at RAS_DEPTH.
  - ret_pop when empty falls back to sequential; no underflow and count stays 0.
  - call_push and ret_pop together: pop first, then push; net count unchanged, top = new address.
  - ret_pop combined with redirect_req: redirect wins for next PC, but the pop is still performed.
  - No RAS change when the transition is not accepted.
- misalign_fault is registered and never held longer than 1 cycle without a new faulting request.
- Reset mid-operation: all state returns to reset values immediately, without waiting for clk.
- All outputs are registered; latency from inputs to curr_pc is 1 clock.

Test Plan:
- Reset release with pc_en = 1, pc_ready = 1: BOOT cycle with pc_valid = 0 and curr_pc = 0, then pc_valid = 1 and curr_pc steps 0, 4, 8, 12.
- Stall: pc_ready = 0 for 3 cycles at curr_pc = 0x10 -> held at 0x10; then redirect_req to 0x200 during the stall -> curr_pc = 0x200 next cycle.
- Misaligned redirect to 0x102 (IALIGN = 4) -> curr_pc held, misalign_fault high exactly 1 cycle. With trap_req and redirect_req together (trap_vec = 0x80, target 0x300) -> curr_pc = 0x80 and RAS cleared.
- RAS:
  - call_push at pc 0x40 with redirect to 0x400, then ret_pop at 0x404 -> curr_pc = 0x44.
  - Five pushes with RAS_DEPTH = 4 then five pops -> four correct LIFO predictions, fifth pop falls back to sequential, ras_empty = 1.
- Wrap and halt:
  - curr_pc = 0xFFFF_FFFC advances to 0x0.
  - halt_req -> halted = 1, pc_valid = 0, PC frozen; resume_req -> continues from the frozen PC.
  - trap_req in HALT -> RUN at trap_vec.
- Assert rst_n low mid-stream between clock edges -> curr_pc = RESET_VECTOR immediately, pc_valid = 0, ras_empty = 1.
